dac_wave_gen: RTL and testbench

Upstream sample source for the DAC7611 serial driver on the U1015 test board. Generates one of five 12-bit waveforms (DC, square, sawtooth, triangle, sine) using an 8-bit phase accumulator. New samples are produced at a programmable sample rate derived from the system clock. Each sample is offered to the downstream serializer through a valid/ready handshake.

---
 rtl/dac_wave_gen.sv | 135 +++++++++++++
 tb/tb_dac_wave_gen.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/dac_wave_gen.sv
// Waveform sample source for the DAC7611 serializer: phase accumulator, five waveform
// shapes, and a valid/ready output stage. Define WAVE_SINE_EN to build the sine LUT.
module dac_wave_gen #(
  parameter int DIV = 300
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        enable,
  input  logic [2:0]  wave_sel,
  input  logic [7:0]  step,
  input  logic [11:0] dc_level,
  output logic [11:0] sample,
  output logic        sample_valid,
  input  logic        sample_ready,
  output logic [7:0]  overrun_cnt
);

  localparam int CW = 10;
  localparam logic [CW-1:0] CNT_MAX = CW'(DIV - 1);

  logic [CW-1:0] cnt_q, cnt_d;
  logic [7:0]    phase_q, phase_d;
  logic [2:0]    active_sel_q, active_sel_d;
  logic [11:0]   sample_q, sample_d;
  logic          valid_q, valid_d;
  logic [7:0]    overrun_q, overrun_d;

  logic          tick;
  logic [7:0]    phase_next;
  logic [6:0]    tri_t;
  logic [11:0]   sine_val;
  logic [11:0]   wave_val;

`ifdef WAVE_SINE_EN
  logic [5:0]  sine_idx;
  logic [10:0] sine_q;

  // Quarter-wave table; the other three quadrants come from index and level mirroring.
  always_comb begin
    sine_idx = phase_q[6] ? ~phase_q[5:0] : phase_q[5:0];
    sine_q   = 11'd0;
    case (sine_idx)
      6'd0:  sine_q = 11'd25;   6'd1:  sine_q = 11'd75;   6'd2:  sine_q = 11'd126;  6'd3:  sine_q = 11'd176;
      6'd4:  sine_q = 11'd226;  6'd5:  sine_q = 11'd275;  6'd6:  sine_q = 11'd325;  6'd7:  sine_q = 11'd375;
      6'd8:  sine_q = 11'd424;  6'd9:  sine_q = 11'd473;  6'd10: sine_q = 11'd522;  6'd11: sine_q = 11'd570;
      6'd12: sine_q = 11'd618;  6'd13: sine_q = 11'd666;  6'd14: sine_q = 11'd713;  6'd15: sine_q = 11'd760;
      6'd16: sine_q = 11'd807;  6'd17: sine_q = 11'd852;  6'd18: sine_q = 11'd898;  6'd19: sine_q = 11'd943;
      6'd20: sine_q = 11'd987;  6'd21: sine_q = 11'd1031; 6'd22: sine_q = 11'd1074; 6'd23: sine_q = 11'd1116;
      6'd24: sine_q = 11'd1158; 6'd25: sine_q = 11'd1199; 6'd26: sine_q = 11'd1239; 6'd27: sine_q = 11'd1279;
      6'd28: sine_q = 11'd1318; 6'd29: sine_q = 11'd1356; 6'd30: sine_q = 11'd1393; 6'd31: sine_q = 11'd1430;
      6'd32: sine_q = 11'd1465; 6'd33: sine_q = 11'd1500; 6'd34: sine_q = 11'd1533; 6'd35: sine_q = 11'd1566;
      6'd36: sine_q = 11'd1598; 6'd37: sine_q = 11'd1629; 6'd38: sine_q = 11'd1659; 6'd39: sine_q = 11'd1688;
      6'd40: sine_q = 11'd1716; 6'd41: sine_q = 11'd1743; 6'd42: sine_q = 11'd1769; 6'd43: sine_q = 11'd1793;
      6'd44: sine_q = 11'd1817; 6'd45: sine_q = 11'd1840; 6'd46: sine_q = 11'd1861; 6'd47: sine_q = 11'd1881;
      6'd48: sine_q = 11'd1901; 6'd49: sine_q = 11'd1919; 6'd50: sine_q = 11'd1936; 6'd51: sine_q = 11'd1951;
      6'd52: sine_q = 11'd1966; 6'd53: sine_q = 11'd1979; 6'd54: sine_q = 11'd1992; 6'd55: sine_q = 11'd2003;
      6'd56: sine_q = 11'd2012; 6'd57: sine_q = 11'd2021; 6'd58: sine_q = 11'd2028; 6'd59: sine_q = 11'd2035;
      6'd60: sine_q = 11'd2039; 6'd61: sine_q = 11'd2043; 6'd62: sine_q = 11'd2046; 6'd63: sine_q = 11'd2047;
      default: sine_q = 11'd0;
    endcase
    sine_val = phase_q[7] ? (12'd2047 - {1'b0, sine_q}) : (12'd2048 + {1'b0, sine_q});
  end
`else
  always_comb sine_val = 12'd2048;
`endif

  always_comb begin
    tri_t    = phase_q[7] ? ~phase_q[6:0] : phase_q[6:0];
    wave_val = dc_level;
    case (active_sel_q)
      3'd1:    wave_val = phase_q[7] ? 12'd0 : 12'd4095;
      3'd2:    wave_val = {phase_q, phase_q[7:4]};
      3'd3:    wave_val = {tri_t, tri_t[6:2]};
      3'd4:    wave_val = sine_val;
      default: wave_val = dc_level;
    endcase
  end

  always_comb begin
    cnt_d        = cnt_q;
    phase_d      = phase_q;
    active_sel_d = active_sel_q;
    sample_d     = sample_q;
    valid_d      = valid_q;
    overrun_d    = overrun_q;
    phase_next   = phase_q + step;
    tick         = enable && (cnt_q == CNT_MAX);

    if (!enable) begin
      cnt_d        = '0;
      active_sel_d = wave_sel;
    end else if (tick) begin
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + CW'(1);
    end

    if (valid_q && sample_ready) valid_d = 1'b0;

    // A tick coinciding with acceptance reloads, so only a still-blocked sample is an overrun.
    if (tick) begin
      phase_d = phase_next;
      if (phase_next < phase_q) active_sel_d = wave_sel;
      if (valid_q && !sample_ready) begin
        if (overrun_q != 8'hFF) overrun_d = overrun_q + 8'd1;
      end else begin
        sample_d = wave_val;
        valid_d  = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q        <= '0;
      phase_q      <= '0;
      active_sel_q <= '0;
      sample_q     <= '0;
      valid_q      <= 1'b0;
      overrun_q    <= '0;
    end else begin
      cnt_q        <= cnt_d;
      phase_q      <= phase_d;
      active_sel_q <= active_sel_d;
      sample_q     <= sample_d;
      valid_q      <= valid_d;
      overrun_q    <= overrun_d;
    end
  end

  assign sample       = sample_q;
  assign sample_valid = valid_q;
  assign overrun_cnt  = overrun_q;

endmodule

// File: tb/tb_dac_wave_gen.sv
// Directed bench for dac_wave_gen at DIV=4; expected samples are hand-computed from the
// waveform definitions. Sine expectations follow WAVE_SINE_EN.
module tb_dac_wave_gen;

  logic        clk = 1'b0;
  logic        reset;
  logic        enable;
  logic [2:0]  wave_sel;
  logic [7:0]  step;
  logic [11:0] dc_level;
  logic [11:0] sample;
  logic        sample_valid;
  logic        sample_ready;
  logic [7:0]  overrun_cnt;

  int compare_count  = 0;
  int mismatch_count = 0;

  dac_wave_gen #(.DIV(4)) dut (
    .clk          (clk),
    .reset        (reset),
    .enable       (enable),
    .wave_sel     (wave_sel),
    .step         (step),
    .dc_level     (dc_level),
    .sample       (sample),
    .sample_valid (sample_valid),
    .sample_ready (sample_ready),
    .overrun_cnt  (overrun_cnt)
  );

  always #5 clk = ~clk;

  task automatic run_clocks(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic check_output(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    compare_count++;
    assert (observed === expected) else begin
      mismatch_count++;
      $error("[TB] FAIL %s: observed %0d expected %0d", tag, observed, expected);
    end
  endtask

  task automatic expect_sample(input string tag, input logic [11:0] value);
    check_output({tag, "_valid"}, 32'(sample_valid), 32'd1);
    check_output({tag, "_sample"}, 32'(sample), 32'(value));
  endtask

  // Reset, let one enable-low cycle load active_sel from wave_sel, then run.
  task automatic apply_stimulus(input logic [2:0] sel, input logic [7:0] stp, input logic rdy, input logic [11:0] dc);
    reset        = 1'b1;
    enable       = 1'b0;
    wave_sel     = sel;
    step         = stp;
    sample_ready = rdy;
    dc_level     = dc;
    run_clocks(1);
    reset = 1'b0;
    run_clocks(1);
    enable = 1'b1;
  endtask

  initial begin
    reset = 1'b1; enable = 1'b0; wave_sel = 3'd0; step = 8'd0; dc_level = 12'd0; sample_ready = 1'b0;
    run_clocks(2);
    check_output("rst_sample", 32'(sample), 32'd0);
    check_output("rst_valid", 32'(sample_valid), 32'd0);
    check_output("rst_overrun", 32'(overrun_cnt), 32'd0);

    $display("[TB] sawtooth step 16");
    apply_stimulus(3'd2, 8'd16, 1'b1, 12'd0);
    run_clocks(3);
    check_output("saw_no_early_tick", 32'(sample_valid), 32'd0);
    run_clocks(1);
    expect_sample("saw_0", 12'd0);
    run_clocks(1);
    check_output("saw_valid_drop", 32'(sample_valid), 32'd0);
    run_clocks(3);
    expect_sample("saw_1", 12'd257);
    run_clocks(4);
    expect_sample("saw_2", 12'd514);
    run_clocks(4);
    expect_sample("saw_3", 12'd771);

    $display("[TB] reset with sample pending");
    reset = 1'b1;
    #1;
    check_output("rst_mid_valid", 32'(sample_valid), 32'd0);
    check_output("rst_mid_sample", 32'(sample), 32'd0);
    dc_level = 12'd1445;
    run_clocks(1);
    reset = 1'b0;
    run_clocks(3);
    check_output("rst_mid_no_early_tick", 32'(sample_valid), 32'd0);
    run_clocks(1);
    expect_sample("rst_mid_first_dc", 12'd1445);

    $display("[TB] backpressure");
    apply_stimulus(3'd2, 8'd16, 1'b0, 12'd0);
    run_clocks(4);
    expect_sample("bp_load", 12'd0);
    run_clocks(4);
    check_output("bp_overrun_1", 32'(overrun_cnt), 32'd1);
    expect_sample("bp_hold_1", 12'd0);
    run_clocks(4);
    check_output("bp_overrun_2", 32'(overrun_cnt), 32'd2);
    expect_sample("bp_hold_2", 12'd0);
    sample_ready = 1'b1;
    run_clocks(1);
    check_output("bp_accept_valid", 32'(sample_valid), 32'd0);
    run_clocks(3);
    expect_sample("bp_next", 12'd771);
    check_output("bp_overrun_kept", 32'(overrun_cnt), 32'd2);
    sample_ready = 1'b0;
    reset = 1'b1;
    #1;
    check_output("bp_rst_overrun", 32'(overrun_cnt), 32'd0);
    check_output("bp_rst_valid", 32'(sample_valid), 32'd0);
    check_output("bp_rst_sample", 32'(sample), 32'd0);

    $display("[TB] tick coinciding with transfer");
    apply_stimulus(3'd2, 8'd16, 1'b0, 12'd0);
    run_clocks(4);
    expect_sample("coin_load", 12'd0);
    run_clocks(3);
    sample_ready = 1'b1;
    run_clocks(1);
    expect_sample("coin_reload", 12'd257);
    check_output("coin_no_overrun", 32'(overrun_cnt), 32'd0);
    run_clocks(1);
    check_output("coin_valid_drop", 32'(sample_valid), 32'd0);

    $display("[TB] overrun saturation");
    apply_stimulus(3'd2, 8'd16, 1'b0, 12'd0);
    run_clocks(4 * 256);
    check_output("sat_reach", 32'(overrun_cnt), 32'd255);
    run_clocks(8);
    check_output("sat_hold", 32'(overrun_cnt), 32'd255);
    check_output("sat_sample", 32'(sample), 32'd0);

    $display("[TB] square step 64");
    apply_stimulus(3'd1, 8'd64, 1'b1, 12'd0);
    run_clocks(4); expect_sample("sq_0", 12'd4095);
    run_clocks(4); expect_sample("sq_1", 12'd4095);
    run_clocks(4); expect_sample("sq_2", 12'd0);
    run_clocks(4); expect_sample("sq_3", 12'd0);
    run_clocks(4); expect_sample("sq_4", 12'd4095);

    $display("[TB] mode switch at period wrap");
    apply_stimulus(3'd2, 8'd64, 1'b1, 12'd0);
    run_clocks(4); expect_sample("ms_0", 12'd0);
    wave_sel = 3'd1;
    run_clocks(4); expect_sample("ms_1", 12'd1028);
    run_clocks(4); expect_sample("ms_2", 12'd2056);
    run_clocks(4); expect_sample("ms_3", 12'd3084);
    run_clocks(4); expect_sample("ms_4", 12'd4095);
    run_clocks(4); expect_sample("ms_5", 12'd4095);
    run_clocks(4); expect_sample("ms_6", 12'd0);
    run_clocks(4); expect_sample("ms_7", 12'd0);

    $display("[TB] triangle step 64");
    apply_stimulus(3'd3, 8'd64, 1'b1, 12'd0);
    run_clocks(4); expect_sample("tri_0", 12'd0);
    run_clocks(4); expect_sample("tri_1", 12'd2064);
    run_clocks(4); expect_sample("tri_2", 12'd4095);
    run_clocks(4); expect_sample("tri_3", 12'd2031);

    $display("[TB] sine step 64");
    apply_stimulus(3'd4, 8'd64, 1'b1, 12'd0);
`ifdef WAVE_SINE_EN
    run_clocks(4); expect_sample("sin_0", 12'd2073);
    run_clocks(4); expect_sample("sin_1", 12'd4095);
    run_clocks(4); expect_sample("sin_2", 12'd2022);
    run_clocks(4); expect_sample("sin_3", 12'd0);
`else
    run_clocks(4); expect_sample("sin_0", 12'd2048);
    run_clocks(4); expect_sample("sin_1", 12'd2048);
    run_clocks(4); expect_sample("sin_2", 12'd2048);
    run_clocks(4); expect_sample("sin_3", 12'd2048);
`endif

    $display("[TB] unused select falls back to dc");
    apply_stimulus(3'd5, 8'd64, 1'b1, 12'd1234);
    run_clocks(4); expect_sample("dc5_0", 12'd1234);
    run_clocks(4); expect_sample("dc5_1", 12'd1234);

    $display("[TB] enable freeze");
    apply_stimulus(3'd2, 8'd16, 1'b1, 12'd0);
    run_clocks(4); expect_sample("frz_0", 12'd0);
    run_clocks(1);
    enable   = 1'b0;
    wave_sel = 3'd1;
    run_clocks(8);
    check_output("frz_no_tick", 32'(sample_valid), 32'd0);
    enable = 1'b1;
    run_clocks(3);
    check_output("frz_restart_no_early_tick", 32'(sample_valid), 32'd0);
    run_clocks(1);
    expect_sample("frz_resume_square", 12'd4095);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compare_count, mismatch_count);
    $finish;
  end

endmodule
